// File: rtl/ibex_pkg.sv
// ibex_pkg (scramble-key slice)
// Purpose : shared widths, FSM state type and LFSR constants for the ICache
//           scramble-key responder and the LFSR helper.
// Contents: SCRAMBLE_KEY_W / SCRAMBLE_NONCE_W, key_srv_state_e,
//           KEY_SRV_LFSR_TAPS, key_srv_lfsr_step().
package ibex_pkg;

    localparam int unsigned SCRAMBLE_KEY_W   = 128;
    localparam int unsigned SCRAMBLE_NONCE_W = 64;

    typedef enum logic [1:0] {
        KS_IDLE,
        KS_WAIT,
        KS_ISSUE,
        KS_DRAIN
    } key_srv_state_e;

    // Galois feedback mask for x^64 + x^63 + x^61 + x^60 + 1 with a right shift:
    // exponent e maps onto bit e-1, giving bits 63, 62, 60 and 59.
    localparam logic [63:0] KEY_SRV_LFSR_TAPS = 64'hD800_0000_0000_0000;

    // One step of the right-shifting Galois LFSR: the bit shifted out of the
    // bottom decides whether the tap mask is folded back in.
    function automatic logic [63:0] key_srv_lfsr_step(input logic [63:0] state);
        logic [63:0] next;
        next = state >> 1;
        if (state[0]) begin
            next = next ^ KEY_SRV_LFSR_TAPS;
        end
        return next;
    endfunction

endpackage

// File: rtl/ibex_scramble_key_lfsr.sv
// ibex_scramble_key_lfsr
// Purpose : purely combinational look-ahead of the key-server LFSR. Given the
//           current state it produces the next three states, so one issue
//           cycle can build a 128-bit key and a 64-bit nonce. The DV reference
//           model instantiates this same block to predict keys.
// Ports   : state_i  in  64  current LFSR state
//           s1_o     out 64  state after one step
//           s2_o     out 64  state after two steps
//           s3_o     out 64  state after three steps
module ibex_scramble_key_lfsr
    import ibex_pkg::*;
(
    input  logic [63:0] state_i,
    output logic [63:0] s1_o,
    output logic [63:0] s2_o,
    output logic [63:0] s3_o
);

    always_comb begin
        s1_o = key_srv_lfsr_step(state_i);
        s2_o = key_srv_lfsr_step(s1_o);
        s3_o = key_srv_lfsr_step(s2_o);
    end

endmodule

// File: rtl/ibex_scramble_key_server.sv
// ibex_scramble_key_server
// Purpose : responder end of the ICache scramble-key handshake, standing in
//           for the OTP/key-manager side on DV and FPGA tops. A held request is
//           accepted from IDLE, a programmable latency elapses, then a fresh
//           key/nonce pair is issued with a one-cycle valid pulse. Keys come
//           from a deterministic LFSR so that scoreboards can predict them.
// Ports   : clk_i                 in   1                 clock
//           rst_i                 in   1                 synchronous active-high reset
//           scramble_req_i        in   1                 request level, held until valid seen
//           latency_i             in   LatencyW          accept-to-issue delay, sampled at accept
//           scramble_key_valid_o  out  1                 one-cycle pulse with a new key
//           scramble_key_o        out  SCRAMBLE_KEY_W    current key
//           scramble_nonce_o      out  SCRAMBLE_NONCE_W  current nonce
//           busy_o                out  1                 FSM is not idle
//           epoch_o               out  EpochW            keys issued since reset (wraps)
module ibex_scramble_key_server
    import ibex_pkg::*;
#(
    parameter int unsigned                  LatencyW   = 8,
    parameter logic [63:0]                  LfsrSeed   = 64'h5EED_1BE5_CAFE_F00D,
    parameter logic [SCRAMBLE_KEY_W-1:0]    ResetKey   = 128'hDDDDDDDDEEEEEEEEAAAAAAAADDDDDDDD,
    parameter logic [SCRAMBLE_NONCE_W-1:0]  ResetNonce = 64'hBBBBEEEEEEEEFFFF,
    parameter int unsigned                  EpochW     = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          scramble_req_i,
    input  logic [LatencyW-1:0]           latency_i,
    output logic                          scramble_key_valid_o,
    output logic [SCRAMBLE_KEY_W-1:0]     scramble_key_o,
    output logic [SCRAMBLE_NONCE_W-1:0]   scramble_nonce_o,
    output logic                          busy_o,
    output logic [EpochW-1:0]             epoch_o
);

    // An all-zero seed would lock the LFSR at zero and every key would be 0.
    if (LfsrSeed == 64'd0) begin : gen_seed_check
        $error("ibex_scramble_key_server: LfsrSeed must be nonzero");
    end

    key_srv_state_e              state_q, state_d;
    logic [LatencyW-1:0]         cnt_q, cnt_d;
    logic [63:0]                 lfsr_q;
    logic [63:0]                 lfsr_s1, lfsr_s2, lfsr_s3;
    logic                        issue;
    logic                        valid_q;
    logic                        busy_q;
    logic [SCRAMBLE_KEY_W-1:0]   key_q;
    logic [SCRAMBLE_NONCE_W-1:0] nonce_q;
    logic [EpochW-1:0]           epoch_q;

    ibex_scramble_key_lfsr u_lfsr (
        .state_i (lfsr_q),
        .s1_o    (lfsr_s1),
        .s2_o    (lfsr_s2),
        .s3_o    (lfsr_s3)
    );

    // Next-state logic. Dropping the request while waiting aborts without
    // touching the LFSR or epoch. DRAIN swallows the consumer's trailing
    // request cycle so a still-high request never produces a second pulse;
    // new requests are only accepted from IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            KS_IDLE: begin
                if (scramble_req_i) begin
                    state_d = KS_WAIT;
                    cnt_d   = latency_i;
                end
            end
            KS_WAIT: begin
                if (!scramble_req_i) begin
                    state_d = KS_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = KS_ISSUE;
                end else begin
                    cnt_d = cnt_q - LatencyW'(1);
                end
            end
            KS_ISSUE: begin
                state_d = KS_DRAIN;
            end
            KS_DRAIN: begin
                if (!scramble_req_i) begin
                    state_d = KS_IDLE;
                end
            end
            default: begin
                state_d = KS_IDLE;
            end
        endcase
    end

    // The edge that enters ISSUE is the one that loads key, nonce and valid,
    // so all three change together and valid is high exactly while the FSM
    // sits in ISSUE.
    assign issue = (state_q == KS_WAIT) && (state_d == KS_ISSUE);

    // State and output registers. busy is registered from the next state so
    // it tracks state != IDLE without a combinational decode on the output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= KS_IDLE;
            cnt_q   <= '0;
            lfsr_q  <= LfsrSeed;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            key_q   <= ResetKey;
            nonce_q <= ResetNonce;
            epoch_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= issue;
            busy_q  <= (state_d != KS_IDLE);
            if (issue) begin
                key_q   <= {lfsr_s1, lfsr_s2};
                nonce_q <= lfsr_s3;
                lfsr_q  <= lfsr_s3;
                epoch_q <= epoch_q + EpochW'(1);
            end
        end
    end

    assign scramble_key_valid_o = valid_q;
    assign scramble_key_o       = key_q;
    assign scramble_nonce_o     = nonce_q;
    assign busy_o               = busy_q;
    assign epoch_o              = epoch_q;

endmodule

// File: tb/tb_ibex_scramble_key_server.sv
// tb_ibex_scramble_key_server
// Purpose : self-checking bench for ibex_scramble_key_server. A driver issues
//           requests and pushes the predicted key/nonce/epoch/cycle into a
//           scoreboard queue; a monitor pops and compares on each valid pulse.
module tb_ibex_scramble_key_server;

    localparam logic [127:0] RESET_KEY   = 128'hDDDDDDDDEEEEEEEEAAAAAAAADDDDDDDD;
    localparam logic [63:0]  RESET_NONCE = 64'hBBBBEEEEEEEEFFFF;
    localparam logic [63:0]  SEED        = 64'h5EED_1BE5_CAFE_F00D;

    typedef struct {
        logic [127:0] key;
        logic [63:0]  nonce;
        logic [15:0]  epoch;
        int           due;
    } scoreEntry_t;

    logic         clk;
    logic         rst;
    logic         scrambleReq;
    logic [7:0]   latency;
    logic         keyValid;
    logic [127:0] key;
    logic [63:0]  nonce;
    logic         busy;
    logic [15:0]  epoch;

    int           compared   = 0;
    int           mismatched = 0;
    int           cycle      = 0;
    int           pulseCount = 0;
    int           dupCount   = 0;

    scoreEntry_t  sbq[$];
    scoreEntry_t  expEntry;
    logic [127:0] issuedKeys[$];
    logic [127:0] lastSeenKey;

    logic [63:0]  modelTaps;
    logic [63:0]  modelLfsr;
    logic [15:0]  modelEpoch;
    logic [127:0] modelKey;

    ibex_scramble_key_server dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .scramble_req_i       (scrambleReq),
        .latency_i            (latency),
        .scramble_key_valid_o (keyValid),
        .scramble_key_o       (key),
        .scramble_nonce_o     (nonce),
        .busy_o               (busy),
        .epoch_o              (epoch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Reference LFSR built from the polynomial exponents, right-shifting Galois.
    function automatic logic [63:0] lfsrNext(input logic [63:0] s);
        logic [63:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ modelTaps;
        return n;
    endfunction

    // Monitor: every pulse must match the oldest prediction, on the right cycle.
    always @(negedge clk) begin
        if (keyValid === 1'b1) begin
            pulseCount++;
            if (sbq.size() == 0) begin
                checkOutput("pulse without accept", 1, 0);
            end else begin
                expEntry = sbq.pop_front();
                checkOutput("key", key, expEntry.key);
                checkOutput("nonce", {64'd0, nonce}, {64'd0, expEntry.nonce});
                checkOutput("epoch", {112'd0, epoch}, {112'd0, expEntry.epoch});
                checkOutput("valid cycle", cycle, expEntry.due);
            end
            foreach (issuedKeys[i]) begin
                if (issuedKeys[i] === key) dupCount++;
            end
            issuedKeys.push_back(key);
            lastSeenKey = key;
        end
    end

    task automatic waitIdle();
        int n = 0;
        while (busy !== 1'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) checkOutput("idle timeout", {127'd0, busy}, 0);
    endtask

    // Drives one request. abortAfter >= 0 drops the request after that many
    // cycles (no prediction pushed); otherwise the request is held until the
    // pulse and for holdAfter further cycles. scrambleLat toggles latency_i
    // while waiting, which must have no effect.
    task automatic applyStimulus(input int lat, input int abortAfter,
                                 input int holdAfter, input bit scrambleLat);
        logic [63:0] s1, s2, s3;
        int budget;
        waitIdle();
        @(negedge clk);
        scrambleReq = 1'b1;
        latency     = lat[7:0];
        if (abortAfter >= 0) begin
            repeat (abortAfter) @(negedge clk);
            scrambleReq = 1'b0;
        end else begin
            s1 = lfsrNext(modelLfsr);
            s2 = lfsrNext(s1);
            s3 = lfsrNext(s2);
            modelEpoch = modelEpoch + 16'd1;
            sbq.push_back('{key: {s1, s2}, nonce: s3, epoch: modelEpoch, due: cycle + lat + 2});
            modelLfsr = s3;
            modelKey  = {s1, s2};
            budget = 0;
            do begin
                @(negedge clk);
                if (scrambleLat) latency = 8'($urandom_range(0, 255));
                budget++;
            end while (keyValid !== 1'b1 && budget < 300);
            if (keyValid !== 1'b1) checkOutput("pulse timeout", 0, 1);
            repeat (holdAfter) @(negedge clk);
            scrambleReq = 1'b0;
        end
    endtask

    initial begin
        int polyExp[4];
        int pulsesBefore;
        logic [127:0] abortedKey;

        polyExp = '{64, 63, 61, 60};
        modelTaps = '0;
        foreach (polyExp[i]) modelTaps[polyExp[i]-1] = 1'b1;
        modelLfsr   = SEED;
        modelEpoch  = '0;
        modelKey    = RESET_KEY;
        rst         = 1'b1;
        scrambleReq = 1'b0;
        latency     = '0;

        // Reset, then idle.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("reset valid", {127'd0, keyValid}, 0);
        checkOutput("reset key", key, RESET_KEY);
        checkOutput("reset nonce", {64'd0, nonce}, {64'd0, RESET_NONCE});
        checkOutput("reset epoch", {112'd0, epoch}, 0);
        checkOutput("reset busy", {127'd0, busy}, 0);

        // Latency 5, consumer drops request one cycle after the pulse.
        applyStimulus(5, -1, 1, 1'b0);
        @(negedge clk);
        checkOutput("busy after drain", {127'd0, busy}, 0);
        checkOutput("epoch after first", {112'd0, epoch}, 1);

        // Latency 0 with request held long after the pulse: exactly one pulse.
        pulsesBefore = pulseCount;
        applyStimulus(0, -1, 6, 1'b0);
        waitIdle();
        repeat (3) @(negedge clk);
        checkOutput("single pulse while held", pulseCount - pulsesBefore, 1);

        // Abort in WAIT: no pulse, key/epoch unchanged, next key is the same.
        pulsesBefore = pulseCount;
        abortedKey = {lfsrNext(modelLfsr), lfsrNext(lfsrNext(modelLfsr))};
        applyStimulus(20, 7, 0, 1'b0);
        repeat (30) @(negedge clk);
        checkOutput("abort no pulse", pulseCount - pulsesBefore, 0);
        checkOutput("abort key kept", key, modelKey);
        checkOutput("abort epoch kept", {112'd0, epoch}, {112'd0, modelEpoch});
        applyStimulus(3, -1, 1, 1'b0);
        checkOutput("key after abort", lastSeenKey, abortedKey);

        // Reset three cycles into WAIT.
        waitIdle();
        pulsesBefore = pulseCount;
        @(negedge clk);
        scrambleReq = 1'b1;
        latency     = 8'd10;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset valid", {127'd0, keyValid}, 0);
        checkOutput("midreset key", key, RESET_KEY);
        checkOutput("midreset nonce", {64'd0, nonce}, {64'd0, RESET_NONCE});
        checkOutput("midreset epoch", {112'd0, epoch}, 0);
        checkOutput("midreset busy", {127'd0, busy}, 0);
        rst         = 1'b0;
        scrambleReq = 1'b0;
        modelLfsr   = SEED;
        modelEpoch  = '0;
        repeat (15) @(negedge clk);
        checkOutput("midreset no pulse", pulseCount - pulsesBefore, 0);

        // Back-to-back traffic with random latencies.
        issuedKeys.delete();
        dupCount = 0;
        pulsesBefore = pulseCount;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(int'($urandom_range(0, 15)), -1, 1, 1'b1);
        end
        waitIdle();
        repeat (3) @(negedge clk);
        checkOutput("b2b pulse count", pulseCount - pulsesBefore, 300);
        checkOutput("b2b epoch", {112'd0, epoch}, 300);
        checkOutput("b2b duplicate keys", dupCount, 0);
        checkOutput("scoreboard drained", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
